// File: rtl/bsg_credit_link_pkg.sv
// Shared definitions for both ends of the credit link: the credit counter width
// and the credit pulse encoding, which is active-high with one pulse per word.
package bsg_credit_link_pkg;

  localparam logic credit_pulse_active_lp = 1'b1;

  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bsg_credit_link_tx_if.sv
// Producer handshake plus link and credit signals of the credit link tx end.
// The slave modport is the tx block; the master modport drives its inputs.
interface bsg_credit_link_tx_if #(
  parameter int width_p         = 16,
  parameter int credit_width_lp = 2
);
  logic                       v_i;
  logic [width_p-1:0]         data_i;
  logic                       ready_o;
  logic                       v_o;
  logic [width_p-1:0]         data_o;
  logic                       credit_i;
  logic [credit_width_lp-1:0] credits_o;
  logic                       idle_o;
  logic                       err_o;

  modport master (
    output v_i, data_i, credit_i,
    input  ready_o, v_o, data_o, credits_o, idle_o, err_o
  );

  modport slave (
    input  v_i, data_i, credit_i,
    output ready_o, v_o, data_o, credits_o, idle_o, err_o
  );
endinterface

// File: rtl/bsg_credit_counter.sv
// Saturating up/down counter. It holds at max_val_p and flags overflow when an
// up arrives alone at the maximum. It never wraps below zero.
module bsg_credit_counter
  import bsg_credit_link_pkg::*;
#(
  parameter  int max_val_p  = 2,
  parameter  int init_val_p = max_val_p,
  localparam int width_lp   = credit_width(max_val_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o,
  output logic                overflow_o
);

  localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);

  logic [width_lp-1:0] count_q, count_d;

  always_comb begin
    count_d    = count_q;
    overflow_o = 1'b0;
    if (up_i && !down_i) begin
      if (count_q == max_lp) overflow_o = 1'b1;
      else                   count_d    = count_q + 1'b1;
    end else if (down_i && !up_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) count_q <= width_lp'(init_val_p);
    else            count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_credit_link_tx.sv
// Credit link transmit end: ready/valid producer in, registered valid/data link out, 1 cycle latency.
// ready_o drops when no remote credits remain. BSG_CREDIT_LINK_TX_ERR_EN enables the sticky overflow flag.
module bsg_credit_link_tx
  import bsg_credit_link_pkg::*;
#(
  parameter  int width_p         = 16,
  parameter  int credits_p       = 2,
  localparam int credit_width_lp = credit_width(credits_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  bsg_credit_link_tx_if.slave link_if
);

  logic                       send;
  logic                       credit_up;
  logic                       overflow;
  logic [credit_width_lp-1:0] count;
  logic                       v_q;
  logic [width_p-1:0]         data_q;

  // ready_o comes only from the registered count, so a returned credit shows up one cycle later.
  assign link_if.ready_o = (count != '0);
  assign send            = link_if.v_i & link_if.ready_o;
  assign credit_up       = (link_if.credit_i == credit_pulse_active_lp);

  bsg_credit_counter #(
    .max_val_p  (credits_p),
    .init_val_p (credits_p)
  ) counter (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .up_i       (credit_up),
    .down_i     (send),
    .count_o    (count),
    .overflow_o (overflow)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q <= send;
      if (send) data_q <= link_if.data_i;
    end
  end

  assign link_if.v_o       = v_q;
  assign link_if.data_o    = data_q;
  assign link_if.credits_o = count;
  assign link_if.idle_o    = (count == credit_width_lp'(credits_p)) & ~v_q;

`ifdef BSG_CREDIT_LINK_TX_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)    err_q <= 1'b0;
    else if (overflow) err_q <= 1'b1;
  end

  assign link_if.err_o = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (!(send && (count == '0)))
      else $error("bsg_credit_link_tx: send with zero credits");
  end
`endif
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign link_if.err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_credit_link_tx.sv
// Bench for bsg_credit_link_tx (credits_p=2, width_p=16): directed scenarios and
// randomized traffic checked against an integer credit/link model.
module tb_bsg_credit_link_tx;

  localparam int W = 16;
  localparam int C = 2;
`ifdef BSG_CREDIT_LINK_TX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bsg_credit_link_tx_if #(.width_p(W), .credit_width_lp(2)) link ();

  bsg_credit_link_tx #(.width_p(W), .credits_p(C)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .link_if   (link.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: remote free slots as an integer, plus the expected link word.
  int      m_cred = C;
  bit      m_v    = 1'b0;
  bit [W-1:0] m_data = '0;
  bit      m_err  = 1'b0;

  task automatic tick();
    bit s;
    int n;
    s = reset_n && link.v_i && (m_cred > 0);
    n = m_cred - int'(s) + int'(link.credit_i);
    if (n > C) n = C;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      m_cred = C; m_v = 1'b0; m_data = '0; m_err = 1'b0;
    end else begin
      if (ERR_EN && link.credit_i && !s && (m_cred == C)) m_err = 1'b1;
      m_cred = n;
      m_v    = s;
      if (s) m_data = link.data_i;
    end
  endtask

  task automatic idle_inputs();
    link.v_i = 1'b0; link.data_i = '0; link.credit_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    n_checks++; if (link.v_o !== 1'b0) $display("FAIL reset_v_o got %b want 0", link.v_o); else n_pass++;
    n_checks++; if (link.data_o !== 16'h0000) $display("FAIL reset_data_o got %h want 0000", link.data_o); else n_pass++;
    n_checks++; if (link.ready_o !== 1'b1) $display("FAIL reset_ready_o got %b want 1", link.ready_o); else n_pass++;
    n_checks++; if (link.credits_o !== 2'd2) $display("FAIL reset_credits_o got %0d want 2", link.credits_o); else n_pass++;
    n_checks++; if (link.idle_o !== 1'b1) $display("FAIL reset_idle_o got %b want 1", link.idle_o); else n_pass++;
    n_checks++; if (link.err_o !== 1'b0) $display("FAIL reset_err_o got %b want 0", link.err_o); else n_pass++;
  endtask

  task automatic test_burst();
    link.v_i = 1'b1; link.data_i = 16'h0001;
    tick();
    n_checks++; if (link.v_o !== 1'b1 || link.data_o !== 16'h0001) $display("FAIL burst_w1 got v=%b d=%h want v=1 d=0001", link.v_o, link.data_o); else n_pass++;
    n_checks++; if (link.idle_o !== 1'b0) $display("FAIL burst_idle got %b want 0", link.idle_o); else n_pass++;
    link.data_i = 16'h0002;
    tick();
    n_checks++; if (link.v_o !== 1'b1 || link.data_o !== 16'h0002) $display("FAIL burst_w2 got v=%b d=%h want v=1 d=0002", link.v_o, link.data_o); else n_pass++;
    n_checks++; if (link.ready_o !== 1'b0 || link.credits_o !== 2'd0) $display("FAIL burst_empty got rdy=%b cr=%0d want rdy=0 cr=0", link.ready_o, link.credits_o); else n_pass++;
    link.data_i = 16'h0003;
    tick(); tick(); tick();
    n_checks++; if (link.v_o !== 1'b0 || link.data_o !== 16'h0002) $display("FAIL burst_hold got v=%b d=%h want v=0 d=0002", link.v_o, link.data_o); else n_pass++;
    n_checks++; if (link.ready_o !== 1'b0 || link.credits_o !== 2'd0) $display("FAIL burst_stall got rdy=%b cr=%0d want rdy=0 cr=0", link.ready_o, link.credits_o); else n_pass++;
  endtask

  task automatic test_credit_return();
    link.credit_i = 1'b1;
    n_checks++; if (link.ready_o !== 1'b0) $display("FAIL credit_same_cycle_ready got %b want 0", link.ready_o); else n_pass++;
    tick();
    link.credit_i = 1'b0;
    n_checks++; if (link.ready_o !== 1'b1 || link.credits_o !== 2'd1) $display("FAIL credit_ready got rdy=%b cr=%0d want rdy=1 cr=1", link.ready_o, link.credits_o); else n_pass++;
    n_checks++; if (link.v_o !== 1'b0) $display("FAIL credit_no_v got %b want 0", link.v_o); else n_pass++;
    tick();
    n_checks++; if (link.v_o !== 1'b1 || link.data_o !== 16'h0003) $display("FAIL credit_w3 got v=%b d=%h want v=1 d=0003", link.v_o, link.data_o); else n_pass++;
    n_checks++; if (link.credits_o !== 2'd0) $display("FAIL credit_after_w3 got %0d want 0", link.credits_o); else n_pass++;
    link.v_i = 1'b0;
    tick();
    n_checks++; if (link.v_o !== 1'b0) $display("FAIL credit_single_pulse got %b want 0", link.v_o); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] d;
    link.credit_i = 1'b1;
    tick();
    n_checks++; if (link.credits_o !== 2'd1) $display("FAIL simul_pre got %0d want 1", link.credits_o); else n_pass++;
    d = W'($urandom);
    link.v_i = 1'b1; link.data_i = d; link.credit_i = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (link.credits_o !== 2'd1 || link.ready_o !== 1'b1) $display("FAIL simul_count got cr=%0d rdy=%b want cr=1 rdy=1", link.credits_o, link.ready_o); else n_pass++;
    n_checks++; if (link.v_o !== 1'b1 || link.data_o !== d) $display("FAIL simul_link got v=%b d=%h want v=1 d=%h", link.v_o, link.data_o, d); else n_pass++;
  endtask

  task automatic test_overflow();
    link.credit_i = 1'b1;
    tick();
    n_checks++; if (link.credits_o !== 2'd2 || link.idle_o !== 1'b1 || link.err_o !== 1'b0) $display("FAIL ovf_full got cr=%0d idle=%b err=%b want cr=2 idle=1 err=0", link.credits_o, link.idle_o, link.err_o); else n_pass++;
    tick();
    link.credit_i = 1'b0;
    n_checks++; if (link.credits_o !== 2'd2) $display("FAIL ovf_saturate got %0d want 2", link.credits_o); else n_pass++;
    n_checks++; if (link.err_o !== ERR_EN) $display("FAIL ovf_err got %b want %b", link.err_o, ERR_EN); else n_pass++;
    link.v_i = 1'b1; link.data_i = 16'h5a5a;
    tick();
    link.v_i = 1'b0; link.credit_i = 1'b1;
    tick();
    link.credit_i = 1'b0;
    tick();
    n_checks++; if (link.err_o !== ERR_EN || link.credits_o !== 2'd2) $display("FAIL ovf_sticky got err=%b cr=%0d want err=%b cr=2", link.err_o, link.credits_o, ERR_EN); else n_pass++;
  endtask

  task automatic test_reset_mid();
    link.v_i = 1'b1; link.data_i = 16'h1111;
    tick();
    link.data_i = 16'h2222;
    tick();
    n_checks++; if (link.credits_o !== 2'd0 || link.v_o !== 1'b1) $display("FAIL rmid_pre got cr=%0d v=%b want cr=0 v=1", link.credits_o, link.v_o); else n_pass++;
    link.v_i = 1'b0; link.credit_i = 1'b1; reset_n = 1'b0;
    tick();
    reset_n = 1'b1; link.credit_i = 1'b0;
    n_checks++; if (link.v_o !== 1'b0 || link.credits_o !== 2'd2) $display("FAIL rmid_state got v=%b cr=%0d want v=0 cr=2", link.v_o, link.credits_o); else n_pass++;
    n_checks++; if (link.ready_o !== 1'b1 || link.idle_o !== 1'b1 || link.err_o !== 1'b0) $display("FAIL rmid_flags got rdy=%b idle=%b err=%b want 1 1 0", link.ready_o, link.idle_o, link.err_o); else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      reset_n       = ($urandom_range(0, 59) != 0);
      link.v_i      = ($urandom_range(0, 3) != 0);
      link.data_i   = W'($urandom);
      link.credit_i = ($urandom_range(0, 2) == 0);
      tick();
      n_checks++;
      if (link.v_o !== m_v || link.data_o !== m_data || link.credits_o !== 2'(m_cred) ||
          link.ready_o !== (m_cred != 0) || link.idle_o !== ((m_cred == C) && !m_v) ||
          link.err_o !== m_err) begin
        if (bad < 10)
          $display("FAIL rand_cycle%0d got v=%b d=%h cr=%0d rdy=%b idle=%b err=%b want v=%b d=%h cr=%0d rdy=%b idle=%b err=%b",
                   i, link.v_o, link.data_o, link.credits_o, link.ready_o, link.idle_o, link.err_o,
                   m_v, m_data, m_cred, (m_cred != 0), ((m_cred == C) && !m_v), m_err);
        bad++;
      end else n_pass++;
    end
    reset_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_burst();
    test_credit_return();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bsg_credit_link_tx.md
Name: bsg_credit_link_tx

Overview:
Transmit end of a credit-flow relay link. Accepts words from a local producer over a ready/valid handshake and launches them onto a registered, non-stallable link (valid/data only, no ready). The receive end is a two-element relay fifo or a deeper fifo of known depth. Flow control uses credits: the remote fifo pulses credit_i once per dequeued word, and the block never launches more words than the remote buffer can hold.

Parameters:
- width_p, 16, data word width in bits.
- credits_p, 2, remote buffer depth, i.e. the initial credit count; legal range 1..255.
- credit_width_lp, derived as $clog2(credits_p+1), width of the credit counter. Local; not overridable.

Ports:
- clk_i, in, 1, clock; all state updates on the rising edge.
- reset_n_i, in, 1, synchronous active-low reset.
- v_i, in, 1, producer word valid.
- data_i, in, width_p, producer word.
- ready_o, out, 1, block can accept a word this cycle.
- v_o, out, 1, link valid (registered).
- data_o, out, width_p, link data (registered).
- credit_i, in, 1, one-cycle pulse from the receiver; returns one credit.
- credits_o, out, credit_width_lp, current credit count.
- idle_o, out, 1, all credits home and link empty.
- err_o, out, 1, sticky credit-overflow flag; see Optional Feature.

Behaviour:
- Reset (reset_n_i=0 at a clock edge) sets:
  - cnt_r = credits_p
  - v_o = 0, data_o = 0
  - err_o = 0
  - Resulting outputs: ready_o = 1, credits_o = credits_p, idle_o = 1.
- ready_o = (cnt_r != 0).
  - Depends only on registered state, with no combinational path from v_i or credit_i.
  - A credit arriving in cycle t raises ready_o at t+1, not at t.
- Handshake: send = v_i & ready_o. The producer may drop v_i or change data_i while ready_o=0, and no word is lost (ready-then-valid).
- Link stage, 1-cycle latency:
  - v_o <= send.
  - data_o <= data_i when send; otherwise data_o holds its value.
  - v_o is high for exactly one cycle per accepted word. Back-to-back sends give consecutive v_o cycles.
- Credit counter update: cnt_next = cnt_r - send + credit_i.
  - send and credit_i in the same cycle: count unchanged.
  - cnt_r = 0 with credit_i = 1: count goes to 1; no send is possible that cycle.
  - Overflow (credit_i = 1, send = 0, cnt_r = credits_p): the count saturates and holds credits_p. This is illegal receiver behaviour.
- credits_o = cnt_r.
- idle_o = (cnt_r == credits_p) & ~v_o.
- Reset mid-operation:
  - In-flight words are abandoned and credits are restored to credits_p.
  - The receiver must be reset in the same cycle; credit_i is ignored while reset_n_i = 0.
- No other state machine. The block is a counter, a link register and control logic.

Optional Feature:
- Macro: BSG_CREDIT_LINK_TX_ERR_EN.
- Defined:
  - err_o is set on the first overflow event and stays 1 until reset.
  - A simulation-only assertion also fires when send occurs with cnt_r = 0; this must be unreachable.
- Undefined:
  - err_o is tied to constant 0 and no error logic is synthesized.
  - Overflow still saturates.

Decomposition:
- Shared package bsg_credit_link_pkg holds:
  - a credit-width function, clog2(n+1);
  - the credit-pulse encoding constant (active-high, one pulse per word), so the tx end and the matching receiver agree.
- One sub-module: bsg_credit_counter, a saturating up/down counter.
  - Parameters: max_val_p, init_val_p.
  - Ports: clk_i, reset_n_i, up_i, down_i, count_o, overflow_o.
  - The tx block instantiates it and adds the link register and handshake logic.

Test Plan:
All scenarios use credits_p=2 and width_p=16.
1. Reset: hold reset_n_i=0 for 2 cycles -> v_o=0, data_o=0x0000, ready_o=1, credits_o=2, idle_o=1, err_o=0.
2. Burst with no credits returned: v_i=1 with words 0x0001, 0x0002, 0x0003 on cycles 0-2 ->
   - words 1 and 2 accepted; v_o=1 on cycles 1-2 with data_o=0x0001 then 0x0002;
   - ready_o=0 from cycle 2; credits_o=0;
   - 0x0003 stays held by the producer; data_o holds 0x0002 afterwards.
3. Credit return: from the state after scenario 2, pulse credit_i in cycle 5 ->
   - ready_o=1 in cycle 6 and 0x0003 accepted;
   - v_o=1 with data_o=0x0003 in cycle 7; credits_o=0 again.
4. Simultaneous send and credit at credits_o=1 -> credits_o stays 1, v_o=1 next cycle, ready_o stays 1.
5. Overflow: credit_i=1 with credits_o=2 and v_i=0 -> credits_o stays 2.
   - err_o=1 and stays set across later traffic with BSG_CREDIT_LINK_TX_ERR_EN defined.
   - err_o=0 without it.
6. Reset mid-burst with credits_o=0 and v_o=1: reset_n_i=0 for one cycle with credit_i=1 -> next cycle v_o=0, credits_o=2, ready_o=1, idle_o=1.
